// File: rtl/cgol_pkg.sv
// Shared constants, operation codes and FSM state type for the CGoL board arbiter.
package cgol_pkg;

    localparam int unsigned ADDR_W = 6;

    localparam logic [1:0] READ_REG  = 2'b00;
    localparam logic [1:0] WRITE_REG = 2'b01;

    // Bit positions inside the one-hot pick vector.
    localparam int unsigned PICK_ENG  = 0;
    localparam int unsigned PICK_DISP = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENG  = 2'd1,
        DISP = 2'd2,
        SWAP = 2'd3
    } state_e;

    function automatic logic op_is_known(input logic [1:0] op);
        return (op == READ_REG) || (op == WRITE_REG);
    endfunction

endpackage

// File: rtl/cgol_board_arbiter_if.sv
// Engine, display, swap-control and bank-memory signals of the board arbiter.
interface cgol_board_arbiter_if #(
    parameter int unsigned ADDR_W = cgol_pkg::ADDR_W
);
    logic              eng_req;
    logic [1:0]        eng_op;
    logic [ADDR_W-1:0] eng_addr;
    logic              eng_wdata;
    logic              eng_gnt;
    logic              eng_rvalid;
    logic              eng_rdata;

    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic              disp_rdata;

    logic              gen_done;
    logic              swap_done;
    logic              cur_bank;

    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic              mem_wdata;
    logic              mem_rdata;

    modport slave (
        input  eng_req, eng_op, eng_addr, eng_wdata,
        output eng_gnt, eng_rvalid, eng_rdata,
        input  disp_req, disp_addr,
        output disp_gnt, disp_rvalid, disp_rdata,
        input  gen_done,
        output swap_done, cur_bank,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output eng_req, eng_op, eng_addr, eng_wdata,
        input  eng_gnt, eng_rvalid, eng_rdata,
        output disp_req, disp_addr,
        input  disp_gnt, disp_rvalid, disp_rdata,
        output gen_done,
        input  swap_done, cur_bank,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/cgol_rr_picker.sv
// Two-requester picker producing a one-hot pick; CGOL_ROUND_ROBIN_EN selects
// alternating tie priority, otherwise the display wins every tie.
module cgol_rr_picker
    import cgol_pkg::*;
(
`ifdef CGOL_ROUND_ROBIN_EN
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       take_i,
`endif
    input  logic       eng_req_i,
    input  logic       disp_req_i,
    output logic [1:0] pick_o
);

`ifdef CGOL_ROUND_ROBIN_EN
    logic eng_prio_q, eng_prio_d;

    // The requester granted last loses the next tie.
    always_comb begin
        eng_prio_d = eng_prio_q;
        if (take_i) begin
            eng_prio_d = pick_o[PICK_DISP];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eng_prio_q <= 1'b1;
        end else begin
            eng_prio_q <= eng_prio_d;
        end
    end

    always_comb begin
        pick_o = '0;
        if (eng_req_i && disp_req_i) begin
            if (eng_prio_q) begin
                pick_o[PICK_ENG] = 1'b1;
            end else begin
                pick_o[PICK_DISP] = 1'b1;
            end
        end else if (eng_req_i) begin
            pick_o[PICK_ENG] = 1'b1;
        end else if (disp_req_i) begin
            pick_o[PICK_DISP] = 1'b1;
        end
    end
`else
    always_comb begin
        pick_o = '0;
        if (disp_req_i) begin
            pick_o[PICK_DISP] = 1'b1;
        end else if (eng_req_i) begin
            pick_o[PICK_ENG] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/cgol_board_arbiter.sv
// Double-buffered CGoL board arbiter: engine/display access to two banks plus bank swap.
// Optional macro CGOL_ROUND_ROBIN_EN enables alternating tie priority in the picker.
module cgol_board_arbiter #(
    parameter int unsigned ADDR_W = cgol_pkg::ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    cgol_board_arbiter_if.slave bus
);
    import cgol_pkg::*;

    state_e          state_q, state_d;
    logic            cur_bank_q, cur_bank_d;
    logic            swap_pending_q, swap_pending_d;
    logic            eng_rvalid_q, eng_rvalid_d;
    logic            disp_rvalid_q, disp_rvalid_d;

    logic            eng_valid;
    logic [1:0]      pick;
    logic            eng_gnt, disp_gnt, swap_done;
    logic            mem_we, mem_wdata;
    logic [ADDR_W:0] mem_addr;

    // Unknown engine opcodes never reach arbitration, so they are simply dropped.
    assign eng_valid = bus.eng_req && op_is_known(bus.eng_op);

    cgol_rr_picker u_picker (
`ifdef CGOL_ROUND_ROBIN_EN
        .clk_i      (clk),
        .rst_i      (rst),
        .take_i     (eng_gnt | disp_gnt),
`endif
        .eng_req_i  (eng_valid),
        .disp_req_i (bus.disp_req),
        .pick_o     (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cur_bank_q     <= 1'b0;
            swap_pending_q <= 1'b0;
            eng_rvalid_q   <= 1'b0;
            disp_rvalid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_bank_q     <= cur_bank_d;
            swap_pending_q <= swap_pending_d;
            eng_rvalid_q   <= eng_rvalid_d;
            disp_rvalid_q  <= disp_rvalid_d;
        end
    end

    // ENG/DISP only record the last grant; they arbitrate exactly like IDLE.
    // A pending swap costs one grant-free cycle before SWAP, so a gen_done that
    // lands in the SWAP cycle itself is still absorbed by the current swap.
    always_comb begin
        state_d        = IDLE;
        cur_bank_d     = cur_bank_q;
        swap_pending_d = swap_pending_q | bus.gen_done;
        eng_rvalid_d   = 1'b0;
        disp_rvalid_d  = 1'b0;
        eng_gnt        = 1'b0;
        disp_gnt       = 1'b0;
        swap_done      = 1'b0;
        mem_we         = 1'b0;
        mem_wdata      = 1'b0;
        mem_addr       = '0;

        case (state_q)
            SWAP: begin
                swap_done      = 1'b1;
                cur_bank_d     = ~cur_bank_q;
                swap_pending_d = 1'b0;
            end
            default: begin
                if (swap_pending_q) begin
                    state_d = SWAP;
                end else if (!rst) begin
                    if (pick[PICK_DISP]) begin
                        disp_gnt      = 1'b1;
                        disp_rvalid_d = 1'b1;
                        mem_addr      = {cur_bank_q, bus.disp_addr};
                        state_d       = DISP;
                    end else if (pick[PICK_ENG]) begin
                        eng_gnt = 1'b1;
                        state_d = ENG;
                        if (bus.eng_op == WRITE_REG) begin
                            mem_we    = 1'b1;
                            mem_wdata = bus.eng_wdata;
                            mem_addr  = {~cur_bank_q, bus.eng_addr};
                        end else begin
                            eng_rvalid_d = 1'b1;
                            mem_addr     = {cur_bank_q, bus.eng_addr};
                        end
                    end
                end
            end
        endcase
    end

    assign bus.eng_gnt     = eng_gnt;
    assign bus.eng_rvalid  = eng_rvalid_q;
    assign bus.eng_rdata   = eng_rvalid_q & bus.mem_rdata;
    assign bus.disp_gnt    = disp_gnt;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.disp_rdata  = disp_rvalid_q & bus.mem_rdata;
    assign bus.swap_done   = swap_done;
    assign bus.cur_bank    = cur_bank_q;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;

endmodule

// File: tb/tb_cgol_board_arbiter.sv
// Directed self-checking bench for cgol_board_arbiter with a 128-cell bank memory model.
module tb_cgol_board_arbiter;
    import cgol_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_init;
    int unsigned n_checks;
    int unsigned n_fail;
    logic [3:0]  exp_e;

    logic        mem [0:127];
    logic        mem_rdata_q;

    cgol_board_arbiter_if #(.ADDR_W(6)) bus ();

    cgol_board_arbiter #(.ADDR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank memory: each cell preloads to its address LSB, 1-cycle read latency.
    assign bus.mem_rdata = mem_rdata_q;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= i[0];
            mem_rdata_q <= 1'b0;
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            mem_rdata_q <= mem[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.eng_req   = 1'b0;
        bus.eng_op    = READ_REG;
        bus.eng_addr  = '0;
        bus.eng_wdata = 1'b0;
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.gen_done  = 1'b0;
    endtask

    task automatic eng_cmd(input logic [1:0] op, input logic [5:0] addr, input logic wdata);
        bus.eng_req   = 1'b1;
        bus.eng_op    = op;
        bus.eng_addr  = addr;
        bus.eng_wdata = wdata;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef CGOL_ROUND_ROBIN_EN
        exp_e = 4'b0101;
`else
        exp_e = 4'b0000;
`endif
        rst      = 1'b1;
        mem_init = 1'b1;
        idle();
        eng_cmd(WRITE_REG, 6'd63, 1'b1);
        bus.disp_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_eng_gnt",   bus.eng_gnt,   0);
        check("rst_disp_gnt",  bus.disp_gnt,  0);
        check("rst_mem_we",    bus.mem_we,    0);
        check("rst_mem_addr",  bus.mem_addr,  0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_swap_done", bus.swap_done, 0);
        check("rst_cur_bank",  bus.cur_bank,  0);
        check("rst_eng_rv",    bus.eng_rvalid, 0);
        check("rst_disp_rv",   bus.disp_rvalid, 0);

        rst      = 1'b0;
        mem_init = 1'b0;
        idle();
        #1;
        check("post_rst_gnt",  bus.eng_gnt | bus.disp_gnt, 0);
        check("post_rst_addr", bus.mem_addr, 0);
        check("post_rst_rv",   bus.eng_rvalid | bus.disp_rvalid, 0);
        check("post_rst_rd",   bus.eng_rdata | bus.disp_rdata, 0);

        // Engine read of cell 9 from bank 0
        next_cycle();
        eng_cmd(READ_REG, 6'd9, 1'b0);
        #1;
        check("rd9_eng_gnt",  bus.eng_gnt,  1);
        check("rd9_disp_gnt", bus.disp_gnt, 0);
        check("rd9_mem_addr", bus.mem_addr, 7'd9);
        check("rd9_mem_we",   bus.mem_we,   0);
        next_cycle();
        idle();
        #1;
        check("rd9_eng_rv",   bus.eng_rvalid, 1);
        check("rd9_eng_rd",   bus.eng_rdata,  1);
        check("rd9_disp_rv",  bus.disp_rvalid, 0);
        check("rd9_gnt_drop", bus.eng_gnt, 0);

        // Engine writes go to the next bank
        next_cycle();
        eng_cmd(WRITE_REG, 6'd63, 1'b1);
        #1;
        check("wr63_gnt",   bus.eng_gnt,   1);
        check("wr63_addr",  bus.mem_addr,  7'd127);
        check("wr63_we",    bus.mem_we,    1);
        check("wr63_wdata", bus.mem_wdata, 1);
        next_cycle();
        idle();
        #1;
        check("wr63_we_off", bus.mem_we,     0);
        check("wr63_no_rv",  bus.eng_rvalid, 0);
        next_cycle();
        eng_cmd(WRITE_REG, 6'd62, 1'b1);
        #1;
        check("wr62_addr", bus.mem_addr, 7'd126);
        check("wr62_we",   bus.mem_we,   1);
        next_cycle();
        idle();
        #1;
        check("wr62_we_off", bus.mem_we, 0);

        // Reserved opcodes are dropped
        next_cycle();
        eng_cmd(2'b10, 6'd9, 1'b1);
        #1;
        check("op10_gnt", bus.eng_gnt, 0);
        check("op10_we",  bus.mem_we,  0);
        next_cycle();
        eng_cmd(2'b11, 6'd9, 1'b1);
        #1;
        check("op11_gnt", bus.eng_gnt, 0);
        next_cycle();
        idle();
        #1;
        check("op11_no_rv", bus.eng_rvalid, 0);

        // Display-only read; leaves the engine favoured for the next tie
        next_cycle();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 6'd5;
        #1;
        check("d5_gnt",     bus.disp_gnt, 1);
        check("d5_eng_gnt", bus.eng_gnt,  0);
        check("d5_addr",    bus.mem_addr, 7'd5);
        next_cycle();
        idle();
        #1;
        check("d5_rv", bus.disp_rvalid, 1);
        check("d5_rd", bus.disp_rdata,  1);

        // Contention for four cycles
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            eng_cmd(READ_REG, 6'd2, 1'b0);
            bus.disp_req  = 1'b1;
            bus.disp_addr = 6'd7;
            #1;
            if (k > 0) begin
                check($sformatf("cont%0d_eng_rv", k),  bus.eng_rvalid,  exp_e[k-1]);
                check($sformatf("cont%0d_disp_rv", k), bus.disp_rvalid, !exp_e[k-1]);
            end
            check($sformatf("cont%0d_eng_gnt", k),  bus.eng_gnt,  exp_e[k]);
            check($sformatf("cont%0d_disp_gnt", k), bus.disp_gnt, !exp_e[k]);
            check($sformatf("cont%0d_addr", k),     bus.mem_addr, exp_e[k] ? 7'd2 : 7'd7);
        end
        next_cycle();
        idle();
        #1;
        check("cont_last_disp_rv", bus.disp_rvalid, !exp_e[3]);
        check("cont_last_disp_rd", bus.disp_rdata,  !exp_e[3]);

        // gen_done during a display grant
        next_cycle();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 6'd3;
        bus.gen_done  = 1'b1;
        #1;
        check("gd_disp_gnt", bus.disp_gnt,  1);
        check("gd_addr",     bus.mem_addr,  7'd3);
        check("gd_swap0",    bus.swap_done, 0);
        next_cycle();
        bus.gen_done = 1'b0;
        eng_cmd(READ_REG, 6'd9, 1'b0);
        #1;
        check("pend_gnt",     bus.eng_gnt | bus.disp_gnt, 0);
        check("pend_swap",    bus.swap_done, 0);
        check("pend_disp_rv", bus.disp_rvalid, 1);
        check("pend_disp_rd", bus.disp_rdata,  1);
        check("pend_bank",    bus.cur_bank, 0);
        next_cycle();
        #1;
        check("swap_gnt",  bus.eng_gnt | bus.disp_gnt, 0);
        check("swap_done", bus.swap_done, 1);
        check("swap_bank", bus.cur_bank, 0);
        check("swap_we",   bus.mem_we, 0);
        next_cycle();
        idle();
        bus.disp_req  = 1'b1;
        bus.disp_addr = 6'd0;
        #1;
        check("aft_bank", bus.cur_bank,  1);
        check("aft_swap", bus.swap_done, 0);
        check("aft_gnt",  bus.disp_gnt,  1);
        check("aft_addr", bus.mem_addr,  7'd64);
        next_cycle();
        idle();
        eng_cmd(READ_REG, 6'd63, 1'b0);
        #1;
        check("b1_rd63_addr", bus.mem_addr,   7'd127);
        check("b1_d0_rd",     bus.disp_rdata, 0);
        next_cycle();
        eng_cmd(READ_REG, 6'd62, 1'b0);
        #1;
        check("b1_rd63_rd",   bus.eng_rdata, 1);
        check("b1_rd62_addr", bus.mem_addr,  7'd126);
        next_cycle();
        idle();
        #1;
        check("b1_rd62_rd", bus.eng_rdata, 1);

        // Two gen_done pulses two cycles apart yield a single swap (bank 1 -> 0)
        next_cycle();
        bus.gen_done = 1'b1;
        #1;
        check("dbl_s0_swap", bus.swap_done, 0);
        next_cycle();
        bus.gen_done = 1'b0;
        #1;
        check("dbl_s1_swap", bus.swap_done, 0);
        check("dbl_s1_bank", bus.cur_bank,  1);
        next_cycle();
        bus.gen_done = 1'b1;
        #1;
        check("dbl_s2_swap", bus.swap_done, 1);
        next_cycle();
        bus.gen_done = 1'b0;
        #1;
        check("dbl_s3_bank", bus.cur_bank,  0);
        check("dbl_s3_swap", bus.swap_done, 0);
        next_cycle();
        #1;
        check("dbl_s4_swap", bus.swap_done, 0);
        next_cycle();
        #1;
        check("dbl_s5_swap", bus.swap_done, 0);
        check("dbl_s5_bank", bus.cur_bank,  0);

        // Move to bank 1, then reset right after a read grant
        next_cycle();
        bus.gen_done = 1'b1;
        next_cycle();
        bus.gen_done = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        check("pre_rst_bank", bus.cur_bank, 1);
        next_cycle();
        eng_cmd(READ_REG, 6'd9, 1'b0);
        #1;
        check("rr_gnt",  bus.eng_gnt,  1);
        check("rr_addr", bus.mem_addr, 7'd73);
        next_cycle();
        rst = 1'b1;
        #1;
        check("mid_rst_rv",   bus.eng_rvalid, 0);
        check("mid_rst_rd",   bus.eng_rdata,  0);
        check("mid_rst_bank", bus.cur_bank,   0);
        check("mid_rst_gnt",  bus.eng_gnt,    0);
        check("mid_rst_addr", bus.mem_addr,   0);
        next_cycle();
        rst = 1'b0;
        idle();
        #1;
        check("rel_rst_rv",   bus.eng_rvalid, 0);
        check("rel_rst_swap", bus.swap_done,  0);
        next_cycle();
        #1;
        check("rel_rst_rv2", bus.eng_rvalid, 0);

        // First tie after reset
        next_cycle();
        eng_cmd(READ_REG, 6'd1, 1'b0);
        bus.disp_req  = 1'b1;
        bus.disp_addr = 6'd4;
        #1;
        check("tie_rst_eng",  bus.eng_gnt,  exp_e[0]);
        check("tie_rst_disp", bus.disp_gnt, !exp_e[0]);
        next_cycle();
        idle();
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cgol_board_arbiter.md
CGOL_BOARD_ARBITER -- requirements
Module: cgol_board_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, cell address width (64-cell board, row[5:3], column[2:0]).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port eng_req  input  1  engine access request.
REQ-005 SHALL have port eng_op  input  2  engine operation: 2'b00 read (current bank), 2'b01 write (next bank); other codes are ignored.
REQ-006 SHALL have port eng_addr  input  ADDR_W  engine cell address.
REQ-007 SHALL have port eng_wdata  input  1  engine write data.
REQ-008 SHALL have ports eng_gnt, eng_rvalid, eng_rdata  output  1 each  engine grant, read-valid and read data.
REQ-009 SHALL have port disp_req  input  1  display-scanner read request.
REQ-010 SHALL have port disp_addr  input  ADDR_W  display cell address.
REQ-011 SHALL have ports disp_gnt, disp_rvalid, disp_rdata  output  1 each  display grant, read-valid and read data.
REQ-012 SHALL have port gen_done  input  1  engine generation-complete pulse; requests a bank swap.
REQ-013 SHALL have port swap_done  output  1  one-cycle pulse when the swap has been applied.
REQ-014 SHALL have port cur_bank  output  1  bank currently holding the live generation.
REQ-015 SHALL have ports mem_we  output  1, mem_addr  output  ADDR_W+1 ({bank,addr}), mem_wdata  output  1, mem_rdata  input  1; memory read latency is 1 cycle.

Function
REQ-016 SHALL implement FSM states IDLE, ENG, DISP and SWAP; at most one grant is asserted per cycle.
REQ-017 SHALL, in IDLE with a pending swap, enter SWAP before servicing any request.
REQ-018 SHALL otherwise arbitrate eng_req/disp_req: display has fixed priority, unless the macro in REQ-029 changes this.
REQ-019 SHALL assert the granted gnt combinationally in the grant cycle and drive mem_addr/mem_we/mem_wdata in that same cycle; each grant lasts exactly one cycle, and the FSM returns to IDLE-equivalent arbitration on the next cycle (back-to-back grants allowed).
REQ-020 SHALL route reads to {cur_bank,addr} and engine writes to {~cur_bank,addr}; mem_we is high only on an engine write grant.
REQ-021 SHALL assert the requester's rvalid with rdata = mem_rdata exactly 1 cycle after its read grant; writes produce no rvalid.
REQ-022 SHALL latch gen_done into a sticky swap_pending flag; a gen_done arriving in the same cycle as a grant completes that grant first.
REQ-023 SHALL, in SWAP, toggle cur_bank, pulse swap_done for one cycle, clear swap_pending, and issue no grant; a second gen_done arriving while swap_pending is already set is absorbed (no double swap).
REQ-024 SHALL ignore an eng_op of 2'b10 or 2'b11: no grant is issued and the request is dropped.

Reset
REQ-025 SHALL, on rst, asynchronously force the FSM to IDLE, cur_bank=0, swap_pending=0, and the round-robin pointer (REQ-029) to favour the engine.
REQ-026 SHALL hold all gnt, rvalid, rdata, mem_we, mem_wdata and swap_done outputs at 0, and mem_addr at 0, during and immediately after reset.
REQ-027 SHALL discard an in-flight read on reset mid-operation (no rvalid after rst).

Configuration
REQ-028 SHALL use the macro CGOL_ROUND_ROBIN_EN.
REQ-029 SHALL, when CGOL_ROUND_ROBIN_EN is defined, alternate priority on contention (the last-granted requester loses the next tie); when it is undefined, the display always wins ties and the pointer logic is absent.

Structure
REQ-030 SHALL take the operation codes (READ_REG=2'b00, WRITE_REG=2'b01), the FSM state enum and ADDR_W from a shared package cgol_pkg.
REQ-031 SHALL place arbitration in one sub-module cgol_rr_picker (inputs: two requests; output: a one-hot pick); the bank/FSM logic stays in the top module.

Verification
REQ-032 SHALL verify that after rst and an engine read of addr 6'd9 with cur_bank=0, mem_addr=7'd9 in the grant cycle and eng_rvalid=1 with eng_rdata=mem_rdata one cycle later.
REQ-033 SHALL verify that an engine write of addr 6'd63 with data 1 gives mem_addr=7'd127 and mem_we=1 for exactly one cycle.
REQ-034 SHALL verify that eng_req and disp_req held high for 4 cycles give D,D,D,D without the macro and E,D,E,D with it.
REQ-035 SHALL verify that gen_done during a display grant completes that grant, then gives SWAP (no grants, swap_done=1, cur_bank 0->1), after which a read of addr 6'd0 drives mem_addr=7'd64.
REQ-036 SHALL verify that two gen_done pulses 2 cycles apart before the swap occurs give exactly one toggle of cur_bank.
REQ-037 SHALL verify that rst asserted the cycle after a read grant gives no rvalid and cur_bank=0.
